// File: rtl/lmsm_sequencer_pkg.sv
// Shared processor package for the LM/SM sequencer.
//   NUM_REGS    : number of architectural registers covered by the mask
//   REG_IDX_W   : width of a register index
//   ADDR_W      : data-memory address width
//   seq_state_t : sequencer state encoding (IDLE=0, ISSUE=1, FINISH=2)
package lmsm_sequencer_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;
  localparam int ADDR_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/lmsm_sequencer_ffs8.sv
// Find-first-set over an 8-bit register mask (purely combinational).
//   mask : input  [NUM_REGS-1:0]  remaining register mask
//   idx  : output [REG_IDX_W-1:0] index of the lowest set bit (0 when none set)
//   any  : output                 1 when at least one bit of mask is set
module ffs8
  import lmsm_sequencer_pkg::*;
(
  input  logic [NUM_REGS-1:0]  mask,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 any
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = REG_IDX_W'(i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer. Expands one load-multiple / store-multiple
// instruction into one single-register micro-op per set mask bit, in
// ascending register order at consecutive addresses, then pulses done.
//   clock        : in  sole clock, rising edge
//   reset        : in  asynchronous, active-low reset
//   start        : in  LM/SM present in the ID/RF slot
//   is_store     : in  1 = SM, 0 = LM (sampled with start)
//   base_addr    : in  [15:0] starting address (sampled with start)
//   reg_mask     : in  [7:0] bit i selects register i (sampled with start)
//   hold         : in  downstream not accepting the micro-op this cycle
//   busy         : out sequence in progress
//   stall_fetch  : out freeze PC / IF-ID / ID-RF
//   uop_valid    : out micro-op valid
//   uop_is_store : out micro-op is a store
//   uop_reg      : out [2:0] register index of micro-op
//   uop_addr     : out [15:0] data-memory address of micro-op
//   done         : out one-cycle completion pulse
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [NUM_REGS-1:0]  reg_mask,
  input  logic                 hold,
  output logic                 busy,
  output logic                 stall_fetch,
  output logic                 uop_valid,
  output logic                 uop_is_store,
  output logic [REG_IDX_W-1:0] uop_reg,
  output logic [ADDR_W-1:0]    uop_addr,
  output logic                 done
);

  seq_state_t           state_reg, state_next;
  logic [NUM_REGS-1:0]  mask_reg, mask_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic                 is_store_reg, is_store_next;

  logic [REG_IDX_W-1:0] sel_idx;
  logic                 sel_any;
  logic [NUM_REGS-1:0]  clear_bit;
  logic [NUM_REGS-1:0]  mask_cleared;

  ffs8 u_ffs8 (
    .mask (mask_reg),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  assign clear_bit    = NUM_REGS'(1) << sel_idx;
  assign mask_cleared = mask_reg & ~clear_bit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      mask_reg     <= '0;
      addr_reg     <= '0;
      is_store_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mask_reg     <= mask_next;
      addr_reg     <= addr_next;
      is_store_reg <= is_store_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    addr_next     = addr_reg;
    is_store_next = is_store_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          is_store_next = is_store;
          addr_next     = base_addr;
          mask_next     = reg_mask;
          state_next    = (|reg_mask) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        // An empty mask cannot normally reach ISSUE; leave cleanly if it does.
        if (!sel_any) begin
          state_next = FINISH;
        end else if (!hold) begin
          mask_next = mask_cleared;
          addr_next = addr_reg + ADDR_W'(1);
          if (mask_cleared == '0) begin
            state_next = FINISH;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Micro-op fields come straight from registers (or a function of the
  // registered mask), so they are glitch-free and read as 0 under reset.
  assign busy         = (state_reg != IDLE);
  assign uop_valid    = (state_reg == ISSUE);
  assign done         = (state_reg == FINISH);
  assign uop_reg      = sel_idx;
  assign uop_addr     = addr_reg;
  assign uop_is_store = is_store_reg;

  // The stall must cover the cycle the instruction is first seen, before
  // busy rises. Gated with reset so every output reads 0 while in reset.
  assign stall_fetch  = busy | ((state_reg == IDLE) & start & reset);

endmodule

// File: tb/tb_lmsm_sequencer.sv
module tb_lmsm_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  reg_mask = '0;
  logic        hold = 1'b0;
  logic        busy, stall_fetch, uop_valid, uop_is_store, done;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] a;
    logic        st;
    logic [31:0] c;
  } uop_t;

  uop_t uop_q[$];
  int   done_q[$];

  lmsm_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .is_store     (is_store),
    .base_addr    (base_addr),
    .reg_mask     (reg_mask),
    .hold         (hold),
    .busy         (busy),
    .stall_fetch  (stall_fetch),
    .uop_valid    (uop_valid),
    .uop_is_store (uop_is_store),
    .uop_reg      (uop_reg),
    .uop_addr     (uop_addr),
    .done         (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a micro-op or done.
  always @(negedge clock) begin
    if (uop_valid) begin
      if (uop_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL uop_unexpected: got reg=%0d addr=%h st=%b cyc=%0d expected none",
                 uop_reg, uop_addr, uop_is_store, cyc);
      end else begin
        uop_t e;
        e = uop_q.pop_front();
        check("uop", {uop_reg, uop_addr, uop_is_store, 32'(cyc)}, e);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done at cyc=%0d expected none", cyc);
      end else begin
        int ec;
        ec = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  task automatic push_uop(input int r, input int a, input int st, input int c);
    uop_t e;
    e.r  = 3'(r);
    e.a  = 16'(a);
    e.st = 1'(st);
    e.c  = 32'(c);
    uop_q.push_back(e);
  endtask

  task automatic start_seq(input logic st, input logic [15:0] base, input logic [7:0] m,
                           output int s);
    @(negedge clock);
    is_store  = st;
    base_addr = base;
    reg_mask  = m;
    start     = 1'b1;
    s         = cyc;
  endtask

  task automatic drop_start;
    @(negedge clock);
    start     = 1'b0;
    is_store  = 1'b0;
    base_addr = '0;
    reg_mask  = '0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy) return;
    end
    total++;
    bad++;
    $display("FAIL idle_timeout: got busy=%b expected 0 within 40 cycles", busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // Reset state, with start high to show stall_fetch is forced low too.
    start = 1'b1;
    #2;
    check("reset_outputs",
          {busy, stall_fetch, uop_valid, uop_is_store, uop_reg, uop_addr, done}, 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // LM, 0x0010, mask 10100101
    start_seq(1'b0, 16'h0010, 8'b1010_0101, s);
    push_uop(0, 'h10, 0, s + 1);
    push_uop(2, 'h11, 0, s + 2);
    push_uop(5, 'h12, 0, s + 3);
    push_uop(7, 'h13, 0, s + 4);
    done_q.push_back(s + 5);
    drop_start();
    wait_idle();

    // SM, empty mask
    start_seq(1'b1, 16'h0040, 8'h00, s);
    done_q.push_back(s + 1);
    #1;
    check("empty_cycleN_stall_busy", {stall_fetch, busy}, 64'b10);
    drop_start();
    #1;
    check("empty_cycleN1_busy_stall_valid", {busy, stall_fetch, uop_valid}, 64'b110);
    @(negedge clock);
    #1;
    check("empty_cycleN2_busy_stall_done", {busy, stall_fetch, done}, 64'b000);
    wait_idle();

    // SM, address wrap
    start_seq(1'b1, 16'hFFFE, 8'b0000_0111, s);
    push_uop(0, 'hFFFE, 1, s + 1);
    push_uop(1, 'hFFFF, 1, s + 2);
    push_uop(2, 'h0000, 1, s + 3);
    done_q.push_back(s + 4);
    drop_start();
    wait_idle();

    // LM with hold for two cycles on the first micro-op
    start_seq(1'b0, 16'h0100, 8'b0000_0011, s);
    push_uop(0, 'h100, 0, s + 1);
    push_uop(0, 'h100, 0, s + 2);
    push_uop(0, 'h100, 0, s + 3);
    push_uop(1, 'h101, 0, s + 4);
    done_q.push_back(s + 5);
    drop_start();
    hold = 1'b1;
    repeat (2) @(negedge clock);
    hold = 1'b0;
    wait_idle();

    // start re-asserted mid-sequence with different operands: ignored
    start_seq(1'b0, 16'h0020, 8'b0001_1000, s);
    push_uop(3, 'h20, 0, s + 1);
    push_uop(4, 'h21, 0, s + 2);
    done_q.push_back(s + 3);
    @(negedge clock);
    is_store  = 1'b1;
    base_addr = 16'h9999;
    reg_mask  = 8'hFF;
    start     = 1'b1;
    drop_start();
    wait_idle();

    // Single top register
    start_seq(1'b0, 16'h1234, 8'h80, s);
    push_uop(7, 'h1234, 0, s + 1);
    done_q.push_back(s + 2);
    drop_start();
    wait_idle();

    // Reset during the second micro-op of a full mask
    start_seq(1'b0, 16'h0200, 8'hFF, s);
    push_uop(0, 'h200, 0, s + 1);
    push_uop(1, 'h201, 0, s + 2);
    drop_start();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_seq_outputs",
          {busy, stall_fetch, uop_valid, uop_is_store, uop_reg, uop_addr, done}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("post_reset_idle", {busy, uop_valid, done}, 64'd0);
    end

    // Fresh full-mask SM after the aborted sequence
    start_seq(1'b1, 16'h0300, 8'hFF, s);
    push_uop(0, 'h300, 1, s + 1);
    push_uop(1, 'h301, 1, s + 2);
    push_uop(2, 'h302, 1, s + 3);
    push_uop(3, 'h303, 1, s + 4);
    push_uop(4, 'h304, 1, s + 5);
    push_uop(5, 'h305, 1, s + 6);
    push_uop(6, 'h306, 1, s + 7);
    push_uop(7, 'h307, 1, s + 8);
    done_q.push_back(s + 9);
    drop_start();
    wait_idle();

    repeat (2) @(negedge clock);
    check("uop_queue_drained", 64'(uop_q.size()), 64'd0);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
